// File: rtl/ipsmacge_txgen.sv
// ipsmacge_txgen: GE MAC TX frame generator (preamble/SFD, byte pacing, IPG).
// Optional FCS append when IPSMACGE_TXGEN_FCS_EN is defined.
module ipsmacge_txgen #(
  parameter int DAT_DW  = 8,
  parameter int MSP_DW  = 2,
  parameter int IPG_MIN = 12,
  parameter int PRE_LEN = 7
) (
  input  logic              txclk,
  input  logic              txrst_,
  input  logic              up_act,
  input  logic [MSP_DW-1:0] up_spd,
  input  logic [DAT_DW-1:0] srcdat,
  input  logic              srcvld,
  input  logic              srcsop,
  input  logic              srceop,
  output logic              srcrdy,
  output logic [DAT_DW-1:0] igdat,
  output logic              igval,
  output logic              igen,
  output logic              iger,
  output logic              txfrm,
  output logic              txund
);

  localparam logic [MSP_DW-1:0] SPD_1G  = MSP_DW'(2);
  localparam logic [MSP_DW-1:0] SPD_RSV = '1;
  localparam logic [7:0]        IPG_LD  = 8'(IPG_MIN - 1);
  localparam logic [7:0]        PRE_LD  = 8'(PRE_LEN - 1);
  localparam logic [DAT_DW-1:0] PRE_B   = DAT_DW'(8'h55);
  localparam logic [DAT_DW-1:0] SFD_B   = DAT_DW'(8'hD5);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    SFD  = 3'd2,
    DATA = 3'd3,
`ifdef IPSMACGE_TXGEN_FCS_EN
    FCS  = 3'd4,
`endif
    ERR  = 3'd5,
    IPG  = 3'd6,
    DROP = 3'd7
  } st_t;

  st_t               state;
  st_t               state_n;
  logic [7:0]        cnt;
  logic [7:0]        cnt_n;
  logic              phase;
  logic              phase_n;
  logic [MSP_DW-1:0] spd;
  logic [MSP_DW-1:0] spd_n;
  logic              eops;
  logic              eops_n;
  logic              abrt;
  logic              abrt_n;

  logic              acc;
  logic              eop_acc;
  logic              off;
  logic              bend;
  logic              bend_n;
  logic              slot_c;
  logic              slot_n;

  logic [DAT_DW-1:0] igdat_d;
  logic              igval_d;
  logic              igen_d;
  logic              iger_d;
  logic              srcrdy_d;
  logic              txfrm_d;
  logic              txund_d;

`ifdef IPSMACGE_TXGEN_FCS_EN
  logic [31:0] crc;

  function automatic logic [31:0] crc_nxt(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  always_ff @(posedge txclk or negedge txrst_) begin
    if (!txrst_) begin
      crc <= '1;
    end else if (state == IDLE) begin
      crc <= '1;
    end else if (acc && (state == SFD || state == DATA)) begin
      crc <= crc_nxt(crc, srcdat[7:0]);
    end
  end
`endif

  always_ff @(posedge txclk or negedge txrst_) begin
    if (!txrst_) begin
      state <= IDLE;
      cnt   <= '0;
      phase <= 1'b0;
      spd   <= '0;
      eops  <= 1'b0;
      abrt  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      phase <= phase_n;
      spd   <= spd_n;
      eops  <= eops_n;
      abrt  <= abrt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    eops_n  = eops;
    abrt_n  = abrt;
    acc     = srcvld & srcrdy;
    eop_acc = acc & srceop;
    off     = ~up_act | (up_spd == SPD_RSV);
    bend    = (spd == SPD_1G) | phase;
    slot_c  = !(state inside {IDLE, DROP});
    if (off && !(state inside {IDLE, DROP, IPG})) begin
      // port pulled mid-frame: drain the rest without IPG
      eops_n  = eops | eop_acc;
      abrt_n  = 1'b1;
      state_n = (eops | eop_acc) ? IDLE : DROP;
    end else begin
      unique case (state)
        IDLE: begin
          if (srcvld && srcsop && !off) begin
            state_n = PRE;
            cnt_n   = PRE_LD;
            eops_n  = 1'b0;
            abrt_n  = 1'b0;
          end
        end
        PRE: begin
          if (bend) begin
            if (cnt == '0) state_n = SFD;
            else           cnt_n   = cnt - 8'd1;
          end
        end
        SFD: begin
          if (bend) begin
            if (acc) begin
              state_n = DATA;
              eops_n  = srceop;
            end else begin
              state_n = ERR;
            end
          end
        end
        DATA: begin
          if (bend) begin
            if (eops) begin
`ifdef IPSMACGE_TXGEN_FCS_EN
              state_n = FCS;
              cnt_n   = 8'd3;
`else
              state_n = IPG;
              cnt_n   = IPG_LD;
`endif
            end else if (acc) begin
              eops_n = srceop;
            end else begin
              state_n = ERR;
            end
          end
        end
`ifdef IPSMACGE_TXGEN_FCS_EN
        FCS: begin
          if (bend) begin
            if (cnt == '0) begin
              state_n = IPG;
              cnt_n   = IPG_LD;
            end else begin
              cnt_n = cnt - 8'd1;
            end
          end
        end
`endif
        ERR: begin
          if (bend) state_n = DROP;
        end
        DROP: begin
          if (eop_acc) begin
            state_n = abrt ? IDLE : IPG;
            cnt_n   = IPG_LD;
          end
        end
        IPG: begin
          if (bend) begin
            if (cnt == '0) state_n = IDLE;
            else           cnt_n   = cnt - 8'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    slot_n  = !(state_n inside {IDLE, DROP});
    phase_n = (slot_c & slot_n) ? ~bend : 1'b0;
    spd_n   = phase_n ? spd : up_spd;
  end

  // outputs are decoded from the next state so they leave a register
  always_comb begin
    bend_n   = (spd_n == SPD_1G) | phase_n;
    igdat_d  = '0;
    igen_d   = 1'b0;
    iger_d   = 1'b0;
    srcrdy_d = 1'b0;
    igval_d  = ~phase_n;
    txund_d  = (state_n == ERR) & (state != ERR);
    txfrm_d  = (state_n == IPG) &
               (state inside {DATA
`ifdef IPSMACGE_TXGEN_FCS_EN
                              , FCS
`endif
                              });
    unique case (state_n)
      IDLE: begin
        srcrdy_d = srcvld & ~srcsop & ~acc;
      end
      PRE: begin
        igen_d  = 1'b1;
        igdat_d = PRE_B;
      end
      SFD: begin
        igen_d   = 1'b1;
        igdat_d  = SFD_B;
        srcrdy_d = bend_n;
      end
      DATA: begin
        igen_d   = 1'b1;
        igdat_d  = acc ? srcdat : igdat;
        srcrdy_d = bend_n & ~eops_n;
      end
`ifdef IPSMACGE_TXGEN_FCS_EN
      FCS: begin
        igen_d  = 1'b1;
        igdat_d = DAT_DW'(~crc[8*(~cnt_n[1:0]) +: 8]);
      end
`endif
      ERR: begin
        igen_d = 1'b1;
        iger_d = 1'b1;
      end
      DROP: begin
        srcrdy_d = 1'b1;
      end
      default: begin
        igen_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge txclk or negedge txrst_) begin
    if (!txrst_) begin
      igdat  <= '0;
      igval  <= 1'b0;
      igen   <= 1'b0;
      iger   <= 1'b0;
      srcrdy <= 1'b0;
      txfrm  <= 1'b0;
      txund  <= 1'b0;
    end else begin
      igdat  <= igdat_d;
      igval  <= igval_d;
      igen   <= igen_d;
      iger   <= iger_d;
      srcrdy <= srcrdy_d;
      txfrm  <= txfrm_d;
      txund  <= txund_d;
    end
  end

endmodule

// File: tb/tb_ipsmacge_txgen.sv
// tb_ipsmacge_txgen: directed frame checks for the GE MAC TX generator.
// Cycle 0 is the first cycle a frame's SOP byte is offered.
`timescale 1ns/1ps
module tb_ipsmacge_txgen;

`ifdef IPSMACGE_TXGEN_FCS_EN
  localparam int FL = 4;
`else
  localparam int FL = 0;
`endif

  logic       txclk = 1'b0;
  logic       txrst_ = 1'b0;
  logic       up_act = 1'b1;
  logic [1:0] up_spd = 2'b10;
  logic [7:0] srcdat = 8'h00;
  logic       srcvld = 1'b0;
  logic       srcsop = 1'b0;
  logic       srceop = 1'b0;
  logic       srcrdy;
  logic [7:0] igdat;
  logic       igval;
  logic       igen;
  logic       iger;
  logic       txfrm;
  logic       txund;

  ipsmacge_txgen dut (
    .txclk  (txclk),
    .txrst_ (txrst_),
    .up_act (up_act),
    .up_spd (up_spd),
    .srcdat (srcdat),
    .srcvld (srcvld),
    .srcsop (srcsop),
    .srceop (srceop),
    .srcrdy (srcrdy),
    .igdat  (igdat),
    .igval  (igval),
    .igen   (igen),
    .iger   (iger),
    .txfrm  (txfrm),
    .txund  (txund)
  );

  always #5 txclk = ~txclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  logic [7:0] sd   [0:63];
  bit         ssop [0:63];
  bit         seop [0:63];
  int nsrc, sp, cyc;
  int gap0, gap1, off0, off1;

  logic [7:0] l_dat [0:127];
  logic       l_val [0:127];
  logic       l_en  [0:127];
  logic       l_er  [0:127];
  logic       l_rdy [0:127];
  logic       l_frm [0:127];
  logic       l_und [0:127];

  task automatic clr_src();
    nsrc = 0;
    sp   = 0;
    cyc  = 0;
    gap0 = -1;
    gap1 = -2;
    off0 = -1;
    off1 = -2;
  endtask

  task automatic add(input logic [7:0] b, input bit s, input bit e);
    sd[nsrc]   = b;
    ssop[nsrc] = s;
    seop[nsrc] = e;
    nsrc++;
  endtask

  task automatic drive();
    srcvld = (sp < nsrc) && !(cyc >= gap0 && cyc <= gap1);
    srcdat = (sp < nsrc) ? sd[sp] : 8'h00;
    srcsop = (sp < nsrc) && ssop[sp];
    srceop = (sp < nsrc) && seop[sp];
    up_act = !(cyc >= off0 && cyc <= off1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      bit a;
      drive();
      if (cyc < 128) begin
        l_dat[cyc] = igdat;
        l_val[cyc] = igval;
        l_en[cyc]  = igen;
        l_er[cyc]  = iger;
        l_rdy[cyc] = srcrdy;
        l_frm[cyc] = txfrm;
        l_und[cyc] = txund;
      end
      a = srcvld && srcrdy;
      @(posedge txclk);
      #1;
      if (a) sp++;
      cyc++;
    end
  endtask

  task automatic do_rst(input logic [1:0] spdv);
    clr_src();
    drive();
    up_spd = spdv;
    txrst_ = 1'b0;
    @(posedge txclk);
    #1;
    txrst_ = 1'b1;
    @(posedge txclk);
    #1;
  endtask

  function automatic int n55(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++)
      if (l_en[i] && l_dat[i] == 8'h55) n++;
    return n;
  endfunction

  function automatic int n_en(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (l_en[i]) n++;
    return n;
  endfunction

  function automatic int n_frm(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (l_frm[i]) n++;
    return n;
  endfunction

  function automatic int n_und(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (l_und[i]) n++;
    return n;
  endfunction

`ifdef IPSMACGE_TXGEN_FCS_EN
  function automatic logic [31:0] ref_fcs(input int nz);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int k = 0; k < nz * 8; k++)
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return ~c;
  endfunction
`endif

  initial begin
    clr_src();
    drive();
    txrst_ = 1'b0;
    #3;
    chk("rst_out",
        {igdat, igval, igen, iger, srcrdy, txfrm, txund}, 0);

    // 1000: 3-byte frame then a 1-byte frame back to back
    do_rst(2'b10);
    add(8'h11, 1, 0);
    add(8'h22, 0, 0);
    add(8'h33, 0, 1);
    add(8'h44, 1, 1);
    run(40 + 2 * FL);
    chk("g_idle", l_en[0], 0);
    chk("g_pre", n55(1, 7), 7);
    chk("g_sfd", {l_en[8], l_dat[8]}, {1'b1, 8'hd5});
    chk("g_data", {l_dat[9], l_dat[10], l_dat[11]}, 24'h112233);
    chk("g_enval",
        {l_en[9], l_en[10], l_en[11],
         l_val[9], l_val[10], l_val[11]}, 6'h3f);
    chk("g_rdy",
        {l_rdy[7], l_rdy[8], l_rdy[9],
         l_rdy[10], l_rdy[11]}, 5'b01110);
    chk("g_ipg", n_en(12 + FL, 24 + FL), 0);
    chk("g_frm", {l_frm[11 + FL], l_frm[12 + FL]}, 2'b01);
    chk("g_b2b", {l_en[25 + FL], l_dat[25 + FL]}, {1'b1, 8'h55});
    chk("g_one",
        {l_en[33 + FL], l_dat[33 + FL], l_en[34 + 2 * FL]},
        {1'b1, 8'h44, 1'b0});
    chk("g_nfrm", n_frm(0, 39 + 2 * FL), 2);

    // 100: two cycles per byte
    do_rst(2'b01);
    add(8'h11, 1, 0);
    add(8'h22, 0, 0);
    add(8'h33, 0, 1);
    run(30 + 2 * FL);
    chk("m_pre", n55(1, 14), 14);
    chk("m_sfd",
        {l_en[15], l_dat[15], l_val[15],
         l_en[16], l_dat[16], l_val[16]},
        {1'b1, 8'hd5, 1'b1, 1'b1, 8'hd5, 1'b0});
    chk("m_rdy",
        {l_rdy[15], l_rdy[16], l_rdy[17], l_rdy[18],
         l_rdy[19], l_rdy[20], l_rdy[21], l_rdy[22]},
        8'b01010100);
    chk("m_dat",
        {l_dat[17], l_dat[18], l_dat[21], l_dat[22]},
        32'h11113333);
    chk("m_val",
        {l_val[17], l_val[18], l_val[19],
         l_val[20], l_val[21], l_val[22]}, 6'b101010);
    chk("m_end",
        {l_en[22], l_en[23 + 2 * FL], l_frm[23 + 2 * FL]},
        3'b101);

    // 1000 underrun after byte 2 of 5
    do_rst(2'b10);
    add(8'ha1, 1, 0);
    add(8'ha2, 0, 0);
    add(8'ha3, 0, 0);
    add(8'ha4, 0, 0);
    add(8'ha5, 0, 1);
    gap0 = 10;
    gap1 = 11;
    run(32);
    chk("u_dat", {l_dat[9], l_dat[10]}, 16'ha1a2);
    chk("u_err",
        {l_en[11], l_er[11], l_dat[11], l_und[11]},
        {1'b1, 1'b1, 8'h00, 1'b1});
    chk("u_nund", n_und(0, 31), 1);
    chk("u_er_end", l_er[12], 0);
    chk("u_drop", n_en(12, 31), 0);
    chk("u_rdy",
        {l_rdy[12], l_rdy[13], l_rdy[14], l_rdy[15]}, 4'b1110);
    chk("u_nfrm", n_frm(0, 31), 0);
    chk("u_sp", sp, 5);

    // stray non-SOP byte while idle
    do_rst(2'b10);
    add(8'haa, 0, 0);
    run(6);
    chk("s_rdy", {l_rdy[0], l_rdy[1], l_rdy[2]}, 3'b010);
    chk("s_en", n_en(0, 5), 0);
    chk("s_sp", sp, 1);

    // port disabled during data byte 1, then a clean frame
    do_rst(2'b10);
    add(8'h11, 1, 0);
    add(8'h22, 0, 0);
    add(8'h33, 0, 1);
    add(8'h44, 1, 0);
    add(8'h55, 0, 1);
    off0 = 9;
    off1 = 9;
    run(30 + FL);
    chk("a_off",
        {l_en[10], l_er[10], l_dat[10], l_rdy[10]},
        {1'b0, 1'b0, 8'h00, 1'b1});
    chk("a_pre", n55(12, 18), 7);
    chk("a_sfd", {l_en[19], l_dat[19]}, {1'b1, 8'hd5});
    chk("a_dat", {l_dat[20], l_dat[21]}, 16'h4455);
    chk("a_frm", l_frm[22 + FL], 1);
    chk("a_nfrm", n_frm(0, 29 + FL), 1);

    // asynchronous reset in the middle of data
    do_rst(2'b10);
    add(8'h11, 1, 0);
    add(8'h22, 0, 0);
    add(8'h33, 0, 0);
    add(8'h44, 0, 0);
    add(8'h55, 0, 1);
    run(10);
    chk("r_mid", {igen, igdat}, {1'b1, 8'h22});
    #2;
    txrst_ = 1'b0;
    #1;
    chk("r_async",
        {igdat, igval, igen, iger, srcrdy, txfrm, txund}, 0);
    clr_src();
    drive();
    #2;
    txrst_ = 1'b1;
    @(posedge txclk);
    #1;
    add(8'h66, 1, 0);
    add(8'h77, 0, 1);
    run(14);
    chk("r_pre", n55(1, 7), 7);
    chk("r_sfd", {l_en[8], l_dat[8]}, {1'b1, 8'hd5});
    chk("r_dat", {l_dat[9], l_dat[10]}, 16'h6677);

`ifdef IPSMACGE_TXGEN_FCS_EN
    do_rst(2'b10);
    for (int i = 0; i < 60; i++) add(8'h00, i == 0, i == 59);
    run(80);
    chk("f_fcs",
        {l_dat[72], l_dat[71], l_dat[70], l_dat[69]},
        ref_fcs(60));
    chk("f_en", {l_en[72], l_en[73], l_frm[73]}, 3'b101);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
